// File: rtl/int_ctrl_n.sv
// int_ctrl_n: Z80 mode-2 style interrupt controller with NCH prioritised channels.
// Channel 0 has the highest priority. The M1/IORQ bus signals are synchronised to
// clk; an M1 falling edge latches the winning channel (pri) and the following IORQ
// falling edge inside that M1 acknowledges it.
// Build option: define INT_CTRL_NESTING_EN to add in-service tracking (isr) that
// blocks the in-service channel and everything of lower priority until eoi_wr.
module int_ctrl_n #(
    parameter int         NCH     = 3,
    parameter logic [6:0] ENA_RST = 7'b0000001
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           m1_n,
    input  logic           iorq_n,
    output logic           int_n,
    input  logic [7:0]     din,
    input  logic           ena_wr,
    input  logic           req_wr,
    input  logic           eoi_wr,
    input  logic [NCH-1:0] int_stbs,
    output logic [7:0]     req_rd,
    output logic [7:0]     ena_rd,
    output logic [7:0]     isr_rd,
    output logic [2:0]     vec_idx
);

    logic           m1_s1, m1_s2, m1_d;
    logic           io_s1, io_s2, io_d;
    logic           m1_start, ack;
    logic [NCH-1:0] req, ena, pri;
    logic [NCH-1:0] req_nx, ena_nx, pri_nx;
    logic [NCH-1:0] blocked, pending;

    // Two-flop synchronisers plus a previous-value flop for falling-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m1_s1 <= 1'b1;
            m1_s2 <= 1'b1;
            m1_d  <= 1'b1;
            io_s1 <= 1'b1;
            io_s2 <= 1'b1;
            io_d  <= 1'b1;
        end else begin
            m1_s1 <= m1_n;
            m1_s2 <= m1_s1;
            m1_d  <= m1_s2;
            io_s1 <= iorq_n;
            io_s2 <= io_s1;
            io_d  <= io_s2;
        end
    end

    assign m1_start = m1_d & ~m1_s2;
    assign ack      = io_d & ~io_s2 & ~m1_s2;
    assign pending  = req & ena & ~blocked;

    // Lowest-index pending channel as a one-hot vector (zero when nothing pending)
    always_comb begin
        pri_nx = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (pending[i]) begin
                pri_nx    = '0;
                pri_nx[i] = 1'b1;
            end
        end
    end

    // Next enable and request values; strobes override the ack-clear, which overrides req_wr
    always_comb begin
        ena_nx = ena;
        req_nx = req;
        for (int i = 0; i < NCH; i++) begin
            if (ena_wr && din[i]) ena_nx[i] = din[7];
            if (req_wr && din[i]) req_nx[i] = din[7];
        end
        if (ack) req_nx = req_nx & ~pri;
        req_nx = req_nx | int_stbs;
    end

    // Control registers, priority latch and the registered INT request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ena   <= ENA_RST[NCH-1:0];
            req   <= '0;
            pri   <= '0;
            int_n <= 1'b1;
        end else begin
            ena   <= ena_nx;
            req   <= req_nx;
            int_n <= ~(|pending);
            if (m1_start) pri <= pri_nx;
        end
    end

`ifdef INT_CTRL_NESTING_EN
    logic [NCH-1:0] isr, isr_nx;

    // EOI retires the highest-priority in-service channel; ack marks the acknowledged one
    always_comb begin
        isr_nx = isr;
        if (eoi_wr) isr_nx = isr & (isr - NCH'(1));
        if (ack)    isr_nx = isr_nx | pri;
    end

    // In-service register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) isr <= '0;
        else        isr <= isr_nx;
    end

    // A channel is blocked when it or any higher-priority channel is in service
    always_comb begin
        logic acc;
        acc     = 1'b0;
        blocked = '0;
        for (int j = 0; j < NCH; j++) begin
            acc        = acc | isr[j];
            blocked[j] = acc;
        end
    end

    assign isr_rd = 8'(isr);
`else
    assign blocked = '0;
    assign isr_rd  = 8'h00;
`endif

    assign req_rd = 8'(req);
    assign ena_rd = 8'(ena);

    // Vector index follows the latched priority vector; 7 when nothing was latched
    always_comb begin
        vec_idx = 3'd7;
        for (int i = 0; i < NCH; i++) begin
            if (pri[i]) vec_idx = 3'(i);
        end
    end

endmodule

// File: doc/int_ctrl_n.md
INT_CTRL_N -- requirements
Module: int_ctrl_n

Interface
REQ-001 SHALL have parameter NCH, default 3, meaning number of interrupt channels (legal range 1..7); channel 0 is highest priority.
REQ-002 SHALL have parameter ENA_RST, default 7'b0000001, meaning reset value of the enable register (low NCH bits used).
REQ-003 SHALL have port clk  input  1  system clock; all logic on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port m1_n  input  1  Z80 M1, asynchronous to clk.
REQ-006 SHALL have port iorq_n  input  1  Z80 IORQ, asynchronous to clk.
REQ-007 SHALL have port int_n  output  1  registered Z80 INT request, active-low.
REQ-008 SHALL have port din  input  8  write data; din[7] is the set/clear value and din[NCH-1:0] is the channel select mask.
REQ-009 SHALL have port ena_wr, req_wr and eoi_wr  input  1 each  single-cycle write strobes.
REQ-010 SHALL have port int_stbs  input  NCH  single-cycle request strobes, one per channel.
REQ-011 SHALL have port req_rd, ena_rd and isr_rd  output  8 each  readback, zero-extended.
REQ-012 SHALL have port vec_idx  output  3  index of the acknowledged channel; 3'd7 means none.

Function
REQ-013 SHALL synchronise m1_n and iorq_n through two flops each; m1 start is synced m1 1->0, and ack is a synced iorq 1->0 edge while synced m1 is low.
REQ-014 SHALL, at m1 start, latch a one-hot pri vector holding the lowest-index channel with req & ena & ~blocked set, or all zero if none.
REQ-015 SHALL drive vec_idx combinationally from pri, with 3'd7 when pri is zero, held stable until the next m1 start.
REQ-016 SHALL, on ena_wr, set every ena bit selected in din[NCH-1:0] to din[7] and leave unselected bits unchanged.
REQ-017 SHALL, per channel, apply req update priority: int_stbs set > ack-clear of the pri channel > req_wr write of din[7] to the selected bits.
REQ-018 SHALL leave req, isr and pri unchanged on an ack with pri zero.
REQ-019 SHALL register int_n = !(|(req & ena & ~blocked)), giving 1 clk latency from the req/ena/isr change to int_n.
REQ-020 SHALL ignore int_stbs bits whose ena bit is clear for int_n purposes while still latching them in req.

Reset
REQ-021 SHALL, while rst_n is low, force ena=ENA_RST, req=0, isr=0, pri=0, int_n=1, vec_idx=7 and all synchroniser flops to 1.
REQ-022 SHALL abandon a reset asserted mid acknowledge with no residual pri or isr state.

Configuration
REQ-023 SHALL use macro INT_CTRL_NESTING_EN to select in-service tracking.
REQ-024 SHALL, with INT_CTRL_NESTING_EN defined: set isr[i] on an ack with pri[i]=1; on eoi_wr clear the lowest-index set isr bit; set blocked[j]=1 for every j >= the lowest-index set isr bit; make eoi_wr with isr=0 a no-op.
REQ-025 SHALL, with INT_CTRL_NESTING_EN undefined: have no isr register, isr_rd=0, blocked=0, and ignore eoi_wr.

Verification
REQ-026 Reset, then int_stbs=3'b100 with ena=001 -> req_rd=8'h04 and int_n stays 1; then ena_wr din=8'h84 -> int_n=0 one clk later.
REQ-027 req=3'b110 and ena=3'b111, run an ack cycle -> vec_idx=1, req becomes 3'b100, int_n stays 0; a second ack -> vec_idx=2, req=0, int_n=1.
REQ-028 Strobe on channel 1 in the same clk as its ack-clear -> req[1] stays 1.
REQ-029 With NESTING_EN: ack channel 1, then strobe channel 2 -> int_n stays 1; strobe channel 0 -> int_n=0; after ack 0, eoi_wr -> isr=8'h02; a second eoi_wr -> isr=0 and channel 2 raises int_n=0.
REQ-030 Ack with no pending request -> vec_idx=7 and all registers unchanged; rst_n pulsed mid ack -> all REQ-021 values.
